// File: rtl/mio_arbiter.sv
// mio_arbiter: two-master round-robin arbiter in front of a single memory/MIO
// port. One transaction at a time, each bounded by a wait-cycle timeout.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no owner; arbitrate and latch the winner's request fields
// ACCESS | drive latched request to memory, count wait cycles
// DONE   | one-cycle ack (and err on timeout) to the owner, then IDLE
module mio_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [2:0]  m0_ctrl,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [2:0]  m1_ctrl,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_ctrl,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // Last ACCESS cycle before abort: the counter reaches TIMEOUT on that edge.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        owner;
  logic        last_grant;
  logic [7:0]  wait_cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  ctrl_q;
  logic [1:0]  grant_q;
  logic        pick;

  // Round-robin winner: a lone requester wins, a tie goes to the master not granted last.
  always_comb begin
    pick = m1_req & (~m0_req | ~last_grant);
  end

  // Memory port carries the latched request only while in ACCESS, zero otherwise.
  always_comb begin
    mem_req   = (state == ACCESS);
    mem_we    = (state == ACCESS) ? we_q    : 1'b0;
    mem_addr  = (state == ACCESS) ? addr_q  : 32'h0;
    mem_wdata = (state == ACCESS) ? wdata_q : 32'h0;
    mem_ctrl  = (state == ACCESS) ? ctrl_q  : 3'b000;
    grant     = grant_q;
    busy      = (state != IDLE);
  end

  // Arbitration / access / completion state machine with registered responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      wait_cnt   <= 8'h0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      ctrl_q     <= 3'b000;
      grant_q    <= 2'b00;
      m0_rdata   <= 32'h0;
      m1_rdata   <= 32'h0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            owner      <= pick;
            last_grant <= pick;
            we_q       <= pick ? m1_we    : m0_we;
            addr_q     <= pick ? m1_addr  : m0_addr;
            wdata_q    <= pick ? m1_wdata : m0_wdata;
            ctrl_q     <= pick ? m1_ctrl  : m0_ctrl;
            grant_q    <= pick ? 2'b10 : 2'b01;
            wait_cnt   <= 8'h0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          // A ready response wins over a timeout landing in the same cycle.
          if (mem_ready) begin
            state <= DONE;
            if (owner) begin
              m1_ack <= 1'b1;
              if (!we_q) m1_rdata <= mem_rdata;
            end else begin
              m0_ack <= 1'b1;
              if (!we_q) m0_rdata <= mem_rdata;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= DONE;
            wait_cnt <= wait_cnt + 8'h1;
            if (owner) begin
              m1_ack   <= 1'b1;
              m1_err   <= 1'b1;
              m1_rdata <= 32'h0;
            end else begin
              m0_ack   <= 1'b1;
              m0_err   <= 1'b1;
              m0_rdata <= 32'h0;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'h1;
          end
        end
        DONE: begin
          state   <= IDLE;
          grant_q <= 2'b00;
        end
        default: begin
          state   <= IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mio_arbiter.sv
// tb_mio_arbiter: directed spec scenarios followed by randomized transactions,
// checked against a transaction-level round-robin/latency model.
module tb_mio_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [2:0]  m0_ctrl, m1_ctrl;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_ctrl;
  logic        mem_ready;
  logic [1:0]  grant;
  logic        busy;

  mio_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ctrl(m0_ctrl), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ctrl(m1_ctrl), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ctrl(mem_ctrl), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // Requester-side stimulus and reference model state
  logic        req_a [2];
  logic        we_a [2];
  logic [31:0] addr_a [2];
  logic [31:0] wdata_a [2];
  logic [2:0]  ctrl_a [2];
  logic [31:0] exp_rd [2];
  int          last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive();
    m0_req = req_a[0]; m0_we = we_a[0]; m0_addr = addr_a[0];
    m0_wdata = wdata_a[0]; m0_ctrl = ctrl_a[0];
    m1_req = req_a[1]; m1_we = we_a[1]; m1_addr = addr_a[1];
    m1_wdata = wdata_a[1]; m1_ctrl = ctrl_a[1];
  endtask

  task automatic set_req(input int m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] ctrl);
    req_a[m] = 1'b1; we_a[m] = we; addr_a[m] = addr;
    wdata_a[m] = wdata; ctrl_a[m] = ctrl;
    drive();
  endtask

  // Runs one transaction starting in an IDLE cycle (called just after a clock edge).
  // k = wait cycles before mem_ready; k >= TO means memory never answers.
  task automatic run_txn(input int k, input bit drop, input logic [31:0] rd, input int exp_w);
    int w, n_acc, t_req;
    bit to;
    logic        e_we;
    logic [31:0] e_addr, e_wdata;
    logic [2:0]  e_ctrl;
    if (req_a[0] && req_a[1]) w = (last == 0) ? 1 : 0;
    else w = req_a[0] ? 0 : 1;
    if (exp_w >= 0) chk("rr_winner", 32'(w), 32'(exp_w));
    last = w;
    e_we = we_a[w]; e_addr = addr_a[w]; e_wdata = wdata_a[w]; e_ctrl = ctrl_a[w];
    to = (k >= TO);
    n_acc = to ? TO : k + 1;
    @(negedge clk);
    chk("idle_grant", 32'(grant), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_mem_req", 32'(mem_req), 32'h0);
    t_req = cyc;
    @(posedge clk); #1;
    for (int i = 0; i < n_acc; i++) begin
      mem_ready = (i == k);
      mem_rdata = (i == k) ? rd : $urandom;
      if (drop && i == 0) begin
        req_a[w] = 1'b0;
        addr_a[w] = $urandom; wdata_a[w] = $urandom; we_a[w] = ~we_a[w];
        drive();
      end
      @(negedge clk);
      chk("acc_mem_req", 32'(mem_req), 32'h1);
      chk("acc_grant", 32'(grant), 32'(2'b01 << w));
      chk("acc_busy", 32'(busy), 32'h1);
      chk("acc_mem_we", 32'(mem_we), 32'(e_we));
      chk("acc_mem_addr", mem_addr, e_addr);
      chk("acc_mem_wdata", mem_wdata, e_wdata);
      chk("acc_mem_ctrl", 32'(mem_ctrl), 32'(e_ctrl));
      chk("acc_no_ack", 32'({m0_ack, m1_ack}), 32'h0);
      @(posedge clk); #1;
    end
    // DONE cycle: stray ready/data must be ignored
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    if (to) exp_rd[w] = 32'h0;
    else if (!e_we) exp_rd[w] = rd;
    @(negedge clk);
    chk("done_ack", 32'({m1_ack, m0_ack}), 32'(2'b01 << w));
    chk("done_err", 32'({m1_err, m0_err}), to ? 32'(2'b01 << w) : 32'h0);
    chk("done_m0_rdata", m0_rdata, exp_rd[0]);
    chk("done_m1_rdata", m1_rdata, exp_rd[1]);
    chk("done_latency", 32'(cyc - t_req), 32'(n_acc + 1));
    chk("done_mem_req", 32'(mem_req), 32'h0);
    chk("done_mem_addr", mem_addr, 32'h0);
    chk("done_grant", 32'(grant), 32'(2'b01 << w));
    req_a[w] = 1'b0;
    drive();
    @(posedge clk); #1;
    chk("post_ack_clear", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'h0);
  endtask

  initial begin
    int k, nr;
    logic [31:0] rd;
    for (int m = 0; m < 2; m++) begin
      req_a[m] = 0; we_a[m] = 0; addr_a[m] = 0; wdata_a[m] = 0; ctrl_a[m] = 0;
      exp_rd[m] = 0;
    end
    drive();
    last = 1;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_outputs", 32'({grant, busy, mem_req, mem_we, m0_ack, m1_ack, m0_err, m1_err}), 32'h0);
    chk("rst_mem_addr", mem_addr | mem_wdata | 32'(mem_ctrl), 32'h0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
    @(posedge clk); #1;

    // Tie after reset: m0, then m1, then next tie m0 again
    set_req(0, 1'b0, 32'h10, 32'h0, 3'b010);
    set_req(1, 1'b0, 32'h20, 32'h0, 3'b010);
    run_txn(1, 0, 32'h1111_0000, 0);
    run_txn(0, 0, 32'h2222_0000, 1);
    set_req(0, 1'b0, 32'h30, 32'h0, 3'b010);
    set_req(1, 1'b0, 32'h40, 32'h0, 3'b010);
    run_txn(2, 0, 32'h3333_0000, 0);
    run_txn(1, 0, 32'h4444_0000, 1);

    // Single load, two waits
    set_req(0, 1'b0, 32'h100, 32'h0, 3'b010);
    run_txn(2, 0, 32'hDEAD_BEEF, 0);
    // Store from m1: rdata must stay put
    set_req(1, 1'b1, 32'h200, 32'h55AA, 3'b010);
    run_txn(3, 0, 32'hCAFE_F00D, 1);
    // Timeout
    set_req(0, 1'b0, 32'h300, 32'h0, 3'b001);
    run_txn(TO + 2, 0, 32'h0, 0);
    // Ready coincides with the timeout cycle
    set_req(1, 1'b0, 32'h400, 32'h0, 3'b100);
    run_txn(TO - 1, 0, 32'hA5A5_5A5A, 1);
    // Requester drops req mid-access
    set_req(0, 1'b0, 32'h500, 32'h0, 3'b010);
    run_txn(2, 1, 32'h1234_5678, 0);

    // Reset during ACCESS
    set_req(1, 1'b0, 32'h600, 32'h0, 3'b010);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rstmid_in_access", 32'(mem_req), 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    req_a[1] = 1'b0;
    drive();
    last = 1;
    exp_rd[0] = 0; exp_rd[1] = 0;
    @(negedge clk);
    chk("rstmid_state", 32'({mem_req, grant, busy}), 32'h0);
    chk("rstmid_no_ack", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'h0);
    chk("rstmid_rdata", m0_rdata | m1_rdata, 32'h0);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("rstmid_no_late_ack", 32'({m0_ack, m1_ack, busy}), 32'h0);
    @(posedge clk); #1;
    set_req(1, 1'b0, 32'h700, 32'h0, 3'b010);
    run_txn(0, 0, 32'h0BAD_CAFE, 1);

    // Randomized traffic
    for (int t = 0; t < 250; t++) begin
      for (int m = 0; m < 2; m++)
        if (!req_a[m] && $urandom_range(0, 1) == 1)
          set_req(m, 1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)));
      if (!req_a[0] && !req_a[1]) begin
        nr = $urandom_range(0, 1);
        set_req(nr, 1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)));
      end
      mem_ready = 1'($urandom_range(0, 1));
      k = $urandom_range(0, TO + 1);
      rd = $urandom;
      run_txn(k, ($urandom_range(0, 7) == 0), rd, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mio_arbiter.md
MIO_ARBITER -- requirements
Module: mio_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum ACCESS cycles without mem_ready before abort (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports m0_req / m1_req  input  1  access request, master 0 = CPU MEM stage, master 1 = loader/debug.
REQ-005 SHALL have ports m0_we / m1_we  input  1  write enable (1 = store, 0 = load).
REQ-006 SHALL have ports m0_addr / m1_addr  input  32  byte address.
REQ-007 SHALL have ports m0_wdata / m1_wdata  input  32  store data.
REQ-008 SHALL have ports m0_ctrl / m1_ctrl  input  3  dm_ctrl access-size code, passed through unmodified.
REQ-009 SHALL have ports m0_rdata / m1_rdata  output  32  registered load data.
REQ-010 SHALL have ports m0_ack / m1_ack  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports m0_err / m1_err  output  1  timeout flag, valid with ack.
REQ-012 SHALL have ports mem_req  output  1; mem_we  output  1; mem_addr  output  32; mem_wdata  output  32; mem_ctrl  output  3: shared memory/MIO port.
REQ-013 SHALL have ports mem_rdata  input  32; mem_ready  input  1: memory response.
REQ-014 SHALL have port grant  output  2  one-hot owner during ACCESS/DONE, 2'b00 in IDLE.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE; no other transitions except reset.
REQ-017 IDLE: if any req high, SHALL select winner, latch its we/addr/wdata/ctrl into internal registers, set grant, enter ACCESS next cycle; with no req, stay IDLE.
REQ-018 Arbitration SHALL be round-robin: single requester always wins; on simultaneous requests the master not granted last wins; last-grant register updates at each grant.
REQ-019 ACCESS: mem_req SHALL be 1 and mem_we/addr/wdata/ctrl SHALL drive latched values, stable for the whole state.
REQ-020 Outside ACCESS, mem_req and mem_we SHALL be 0; mem_addr/wdata/ctrl SHALL be 0.
REQ-021 ACCESS SHALL keep an 8-bit wait counter, cleared on entry, incremented each ACCESS cycle with mem_ready low.
REQ-022 mem_ready high in ACCESS SHALL move to DONE; for loads mem_rdata SHALL be captured into owner's rdata on that edge; for stores owner's rdata SHALL be unchanged.
REQ-023 Counter reaching TIMEOUT with mem_ready low SHALL move to DONE with owner's err set and owner's rdata forced to 0.
REQ-024 mem_ready and timeout in the same cycle: mem_ready SHALL take precedence (normal completion, err=0).
REQ-025 DONE: owner's ack SHALL be 1 for exactly this one cycle; err valid this cycle only; non-owner ack/err SHALL be 0; next state IDLE.
REQ-026 Latency: req sampled in IDLE at cycle T, mem_ready first seen at T+1+k (k wait cycles) -> ack at T+2+k; minimum req-to-ack 2 cycles.
REQ-027 Requester SHALL hold req and fields until ack; req deassertion during ACCESS SHALL NOT abort the transaction (ack still issued).
REQ-028 Requests arriving during ACCESS/DONE SHALL wait; arbitration only in IDLE, so back-to-back grants are separated by one IDLE cycle.
REQ-029 mem_ready high outside ACCESS SHALL be ignored.
REQ-030 rdata SHALL hold its value until the next completed load for that master.

Reset
REQ-031 On reset: state IDLE, grant 00, busy 0, mem_* outputs 0, all ack/err 0, m0/m1_rdata 0, wait counter 0, last-grant = master 1 (master 0 wins first tie).
REQ-032 Reset during ACCESS or DONE SHALL abandon the transaction without ack; mem_req low from the cycle after the reset edge.

Verification
REQ-033 Single load: m0 read addr 0x100, mem_ready after 2 waits with rdata 0xDEADBEEF -> m0_ack pulse 4 cycles after req, m0_rdata=0xDEADBEEF, m0_err=0.
REQ-034 Tie: m0 and m1 request same cycle after reset -> m0 granted first, m1 granted after m0 DONE+IDLE; second tie -> m0 granted after m1 (alternation).
REQ-035 Timeout: TIMEOUT=4, mem_ready never asserts -> DONE after 4 ACCESS cycles, owner ack=1 err=1 rdata=0.
REQ-036 Store: m1 write 0x55AA to 0x200 ctrl 3'b010 -> mem_we=1, mem_addr=0x200, mem_wdata=0x55AA, mem_ctrl=010 held stable until mem_ready; m1_rdata unchanged.
REQ-037 Reset asserted mid-ACCESS -> no ack, mem_req=0, grant=00, busy=0 next cycle; fresh request afterward completes normally.
REQ-038 mem_ready and timeout coincide (ready on cycle TIMEOUT) -> ack with err=0 and captured data.
